// File: rtl/rom_reader_pkg.sv
// ---------------------------------------------------------------------------
// rom_reader_pkg
// Shared definitions for the ROM message reader:
//   - FSM state encoding
//   - default address/data widths
//   - default terminator code
// ---------------------------------------------------------------------------
package rom_reader_pkg;

    localparam int         ADDR_W_DEF = 4;
    localparam int         DATA_W_DEF = 8;
    localparam logic [7:0] TERM_DEF   = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/rom_msg_reader.sv
// ---------------------------------------------------------------------------
// rom_msg_reader
// Walks a combinational character ROM from address 0 and streams each
// character to a downstream consumer over valid/ready until the terminator
// code is read or MAX_LEN characters have been sent. One message per start.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        message request, only looked at while idle
//   stop         (ROM_READER_REPEAT_EN only) end repeat mode after this pass
//   rom_addr     registered ROM address
//   rom_data     combinational ROM data for rom_addr
//   tx_data      registered character to the consumer
//   tx_valid     tx_data valid
//   tx_ready     consumer accepts on tx_valid & tx_ready
//   busy         FSM not idle
//   done         one-cycle pulse at end of each message
//   char_count   characters accepted in current/last message
//
// Build option
//   ROM_READER_REPEAT_EN  when defined, the message is resent back to back
//                         until stop is seen; otherwise single-shot.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, rom_addr held at 0
// FETCH   | capture rom_data; terminator ends the message
// PRESENT | tx_data/tx_valid held until the consumer accepts
// DONE    | done pulse, rom_addr back to 0
// ---------------------------------------------------------------------------
module rom_msg_reader
    import rom_reader_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                MAX_LEN = 16,
    parameter logic [DATA_W-1:0] TERM    = DATA_W'(TERM_DEF)
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef ROM_READER_REPEAT_EN
    input  logic              stop,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   char_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_LEN - 1);

    state_e            state_q;
    logic              start_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              done_q;
    logic [ADDR_W:0]   count_q;
`ifdef ROM_READER_REPEAT_EN
    logic              stop_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
`ifdef ROM_READER_REPEAT_EN
            stop_q  <= 1'b0;
`endif
        end else begin
            // start is registered once before use, so a request seen at one
            // edge produces tx_valid two edges later.
            start_q <= start && (state_q == ST_IDLE);
            done_q  <= 1'b0;
`ifdef ROM_READER_REPEAT_EN
            if (state_q == ST_IDLE) begin
                stop_q <= 1'b0;
            end else if (stop) begin
                stop_q <= 1'b1;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    addr_q <= '0;
                    if (start_q) begin
                        count_q <= '0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (rom_data == TERM) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        data_q  <= rom_data;
                        valid_q <= 1'b1;
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (valid_q && tx_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 1'b1;
                        // last slot ends the message without wrapping rom_addr
                        if (addr_q == LAST_ADDR) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    addr_q <= '0;
`ifdef ROM_READER_REPEAT_EN
                    if (stop_q || stop) begin
                        state_q <= ST_IDLE;
                    end else begin
                        count_q <= '0;
                        state_q <= ST_FETCH;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom_addr   = addr_q;
    assign tx_data    = data_q;
    assign tx_valid   = valid_q;
    assign done       = done_q;
    assign char_count = count_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_msg_reader.sv
`timescale 1ns/1ps
module tb_rom_msg_reader;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int ML = 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          tx_ready = 1'b0;
`ifdef ROM_READER_REPEAT_EN
    logic          stop     = 1'b1;
`endif
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   char_count;

    logic [DW-1:0] rom [ML];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    rom_msg_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef ROM_READER_REPEAT_EN
        .stop       (stop),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .char_count (char_count)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q [$];
    int            exp_done_q [$];
    int            ready_mode = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            done_cnt = 0;
    int            last_acc_cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Consumer: ready tied high or randomly toggled, driven just after the edge.
    always @(posedge clk) begin
        #1;
        tx_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard whenever a character is accepted or done pulses.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        int            ec;
        cyc = cyc + 1;
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_char: got %0h, expected no character", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("char", tx_data, e);
                end
                check("char_addr", rom_addr, acc_cnt);
                check("running_count", char_count, acc_cnt);
                if (ready_mode == 0 && acc_cnt > 0)
                    check("throughput", cyc - last_acc_cyc, 2);
                last_acc_cyc = cyc;
                acc_cnt++;
            end
            if (done) begin
                check("done_no_valid", tx_valid, 0);
                if (exp_done_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done with char_count %0d, expected none", char_count);
                end else begin
                    ec = exp_done_q.pop_front();
                    check("done_count", char_count, ec);
                end
                done_cnt++;
                acc_cnt = 0;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference model: message is the ROM prefix before the first terminator, capped at ML.
    function automatic int model_len();
        int n = 0;
        for (int i = 0; i < ML; i++) begin
            if (rom[i] == 8'h00) break;
            n++;
        end
        return n;
    endfunction

    task automatic push_expected();
        int n = model_len();
        for (int i = 0; i < n; i++) exp_q.push_back(rom[i]);
        exp_done_q.push_back(n);
    endtask

    task automatic load_student();
        logic [7:0] s [8];
        s = '{8'h53, 8'h54, 8'h55, 8'h44, 8'h45, 8'h4E, 8'h54, 8'h00};
        for (int i = 0; i < ML; i++) rom[i] = (i < 8) ? s[i] : 8'hFF;
    endtask

    task automatic send_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_msg(input string tag, input bit poke_busy);
        int n, lat, vlat;
        bit ok;
        n    = model_len();
        push_expected();
        acc_cnt = 0;
        send_start();
        lat  = 0;
        vlat = -1;
        ok   = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            lat++;
            if (poke_busy && n >= 4 && lat == 6) start = 1'b1;
            if (poke_busy && n >= 4 && lat == 7) start = 1'b0;
            if (tx_valid && vlat < 0) vlat = lat;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done, expected done within 600 cycles", tag);
        end
        if (n > 0) begin
            check({tag, "_valid_latency"}, vlat, 3);
        end else begin
            check({tag, "_done_latency"}, lat, 3);
            check({tag, "_no_valid"}, vlat, -1);
        end
        for (int i = 0; i < 6; i++) @(negedge clk);
        check({tag, "_addr_idle"}, rom_addr, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_final_count"}, char_count, n);
        check({tag, "_q_empty"}, exp_q.size(), 0);
        check({tag, "_done_q_empty"}, exp_done_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int pos;
        load_student();

        // reset state
        #12;
        check("reset_tx_valid", tx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_addr", rom_addr, 0);
        check("reset_count", char_count, 0);
        check("reset_tx_data", tx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: plain message, ready tied high
        ready_mode = 0;
        run_msg("student", 1'b0);

        // 2: random backpressure, plus a start request while busy
        ready_mode = 1;
        run_msg("backpressure", 1'b1);
        run_msg("backpressure2", 1'b0);

        // 3: empty message
        ready_mode = 0;
        rom[0] = 8'h00;
        run_msg("empty", 1'b0);

        // 4: no terminator anywhere
        for (int i = 0; i < ML; i++) rom[i] = 8'(8'h41 + i);
        run_msg("full16", 1'b0);
        ready_mode = 1;
        run_msg("full16_bp", 1'b0);

        // random contents with random terminator position (ML means none)
        for (int t = 0; t < 6; t++) begin
            pos = $urandom_range(0, ML);
            for (int i = 0; i < ML; i++) rom[i] = 8'($urandom_range(1, 255));
            if (pos < ML) rom[pos] = 8'h00;
            ready_mode = t % 2;
            run_msg("random", 1'($urandom_range(0, 1)));
        end

        // 5: reset mid-message
        load_student();
        ready_mode = 0;
        push_expected();
        acc_cnt = 0;
        send_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (acc_cnt >= 3 && tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_reached_char4", ok, 1);
        rst_n = 1'b0;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_count", char_count, 0);
        check("rst_tx_data", tx_data, 0);
        exp_q.delete();
        exp_done_q.delete();
        acc_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_msg("after_reset", 1'b0);

`ifdef ROM_READER_REPEAT_EN
        // 6: continuous repeat, stop raised during the third pass
        begin
            int  base;
            bit  stopped;
            load_student();
            ready_mode = 0;
            stop = 1'b0;
            for (int p = 0; p < 3; p++) push_expected();
            acc_cnt = 0;
            base    = done_cnt;
            stopped = 1'b0;
            ok      = 1'b0;
            send_start();
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                #1;
                if (!stopped && done_cnt == base + 2 && acc_cnt == 3) begin
                    stop    = 1'b1;
                    stopped = 1'b1;
                    @(negedge clk);
                    #1 stop = 1'b0;
                end
                if (stopped && !busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("repeat_stopped", ok, 1);
            repeat (6) @(negedge clk);
            check("repeat_done_pulses", done_cnt - base, 3);
            check("repeat_q_empty", exp_q.size(), 0);
            check("repeat_busy", busy, 0);
            check("repeat_count", char_count, 7);
            check("repeat_addr", rom_addr, 0);
            stop = 1'b1;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
